// File: rtl/tpu_pkg.sv
// Shared types and helpers for the systolic-array front end.
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_e;

    // Bit offset of a lane inside a packed multi-lane vector.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/utils_sync_fifo.sv
// Synchronous FIFO with registered storage. Data written in one cycle is readable
// in the next cycle at the earliest. Push on full and pop on empty are ignored.
module utils_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/act_skew_feeder.sv
// Activation feeder for the weight-stationary array: buffers input vectors, drives
// row r delayed by r cycles, and sequences each tile as clear, stream, flush, done.
module act_skew_feeder
    import tpu_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [LEN_WIDTH-1:0]       len_i,
    input  logic                       in_vld_i,
    output logic                       in_rdy_o,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data_i,
    output logic [ROWS*DATA_WIDTH-1:0] act_o,
    output logic [ROWS-1:0]            act_vld_o,
    output logic                       clear_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int VW = ROWS * DATA_WIDTH;
    localparam int FW = $clog2(ROWS) + 1;

    feeder_state_e        state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
    logic [FW-1:0]        flush_cnt_q, flush_cnt_d;
    logic                 clear_q, clear_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic [VW-1:0] fifo_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    utils_sync_fifo #(
        .WIDTH (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (in_vld_i),
        .data_i  (in_data_i),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_rdy_o = !fifo_full;
    assign clear_o  = clear_q;
    assign done_o   = done_q;
    assign busy_o   = busy_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pop_cnt_d   = pop_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        len_d     = len_i;
                        pop_cnt_d = '0;
                        state_d   = CLEAR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CLEAR: state_d = STREAM;
            STREAM: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    pop_cnt_d = pop_cnt_q + LEN_WIDTH'(1);
                    // Compare before incrementing so the counter never has to exceed len.
                    if (pop_cnt_q == len_q - LEN_WIDTH'(1)) begin
                        flush_cnt_d = '0;
                        state_d     = FLUSH;
                    end
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + FW'(1);
                if (flush_cnt_q == FW'(ROWS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        clear_d = (state_d == CLEAR);
        done_d  = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            len_q       <= '0;
            pop_cnt_q   <= '0;
            flush_cnt_q <= '0;
            clear_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pop_cnt_q   <= pop_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            clear_q     <= clear_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    // Lane r is a shift register r+1 deep; the last stage is the output register.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        localparam int LSB = lane_lsb(r, DATA_WIDTH);

        logic [DATA_WIDTH-1:0] dat_q [r+1];
        logic [DATA_WIDTH-1:0] dat_d [r+1];
        logic [r:0]            vld_q, vld_d;

        always_comb begin
            dat_d    = dat_q;
            vld_d    = vld_q;
            dat_d[0] = pop ? fifo_data[LSB +: DATA_WIDTH] : '0;
            vld_d[0] = pop;
            for (int k = 1; k <= r; k++) begin
                dat_d[k] = dat_q[k-1];
                vld_d[k] = vld_q[k-1];
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int k = 0; k <= r; k++) begin
                    dat_q[k] <= '0;
                end
                vld_q <= '0;
            end else begin
                dat_q <= dat_d;
                vld_q <= vld_d;
            end
        end

        assign act_o[LSB +: DATA_WIDTH] = dat_q[r];
        assign act_vld_o[r]             = vld_q[r];
    end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Bench for act_skew_feeder: scenario tasks with inline checks and per-lane expected queues.
module tb_act_skew_feeder;

    localparam int ROWS  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 16;
    localparam int VW    = ROWS * DW;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [LW-1:0]   len;
    logic            in_vld;
    logic            in_rdy;
    logic [VW-1:0]   in_data;
    logic [VW-1:0]   act;
    logic [ROWS-1:0] act_vld;
    logic            clear;
    logic            busy;
    logic            done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_q [ROWS][$];

    always #5 clk = ~clk;

    act_skew_feeder #(
        .ROWS       (ROWS),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .len_i     (len),
        .in_vld_i  (in_vld),
        .in_rdy_o  (in_rdy),
        .in_data_i (in_data),
        .act_o     (act),
        .act_vld_o (act_vld),
        .clear_o   (clear),
        .busy_o    (busy),
        .done_o    (done)
    );

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] make_vec(input int base, input int step);
        logic [VW-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
            v[r*DW +: DW] = DW'(base + r * step);
        end
        return v;
    endfunction

    task automatic push_exp(input logic [VW-1:0] v);
        for (int r = 0; r < ROWS; r++) begin
            exp_q[r].push_back(v[r*DW +: DW]);
        end
    endtask

    task automatic flush_exp();
        for (int r = 0; r < ROWS; r++) begin
            exp_q[r].delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_tests++;
        if ({act, act_vld, clear, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got act=%h vld=%b clr=%b busy=%b done=%b, expected all 0",
                     act, act_vld, clear, busy, done);
        end
        n_tests++;
        if (in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_rdy: got %b, expected 1", in_rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            n_tests++;
            if ({act, act_vld, clear, busy, done} !== '0 || in_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_idle: cycle %0d got act=%h vld=%b clr=%b busy=%b done=%b rdy=%b, expected zeros and rdy=1",
                         n, act, act_vld, clear, busy, done, in_rdy);
            end
        end
        tick();
    endtask

    task automatic test_prefill();
        logic [ROWS-1:0] exp_vld;
        logic [DW-1:0]   got, want;
        for (int k = 0; k < 3; k++) begin
            in_vld  = 1'b1;
            in_data = make_vec(4 * k + 1, 1);
            @(negedge clk);
            n_tests++;
            if (in_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL prefill_rdy: vector %0d got %b, expected 1", k, in_rdy);
            end
            push_exp(in_data);
            tick();
        end
        in_vld = 1'b0;
        start  = 1'b1;
        len    = LW'(3);
        tick();
        start  = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            for (int r = 0; r < ROWS; r++) begin
                exp_vld[r] = (n >= 3 + r) && (n <= 5 + r);
            end
            n_tests++;
            if (act_vld !== exp_vld) begin
                n_fail++;
                $display("FAIL prefill_vld: cycle %0d got %b, expected %b", n, act_vld, exp_vld);
            end
            n_tests++;
            if (clear !== (n == 1) || done !== (n == 9) || busy !== (n <= 9)) begin
                n_fail++;
                $display("FAIL prefill_ctrl: cycle %0d got clr=%b done=%b busy=%b, expected %b %b %b",
                         n, clear, done, busy, n == 1, n == 9, n <= 9);
            end
            for (int r = 0; r < ROWS; r++) begin
                got = act[r*DW +: DW];
                n_tests++;
                if (act_vld[r]) begin
                    if (exp_q[r].size() == 0) begin
                        n_fail++;
                        $display("FAIL prefill_lane%0d_extra: cycle %0d got %0d, expected none", r, n, got);
                    end else begin
                        want = exp_q[r].pop_front();
                        if (got !== want) begin
                            n_fail++;
                            $display("FAIL prefill_lane%0d_data: cycle %0d got %0d, expected %0d", r, n, got, want);
                        end
                    end
                end else if (got !== '0) begin
                    n_fail++;
                    $display("FAIL prefill_lane%0d_bubble: cycle %0d got %0d, expected 0", r, n, got);
                end
            end
            tick();
        end
    endtask

    task automatic test_underflow();
        logic [ROWS-1:0] exp_vld;
        logic [DW-1:0]   got, want;
        start = 1'b1;
        len   = LW'(2);
        tick();
        start = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            in_vld  = (n == 4) || (n == 6);
            in_data = (n == 4) ? make_vec(1, 0) : (n == 6) ? make_vec(2, 0) : '0;
            @(negedge clk);
            if (in_vld) begin
                n_tests++;
                if (in_rdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL underflow_rdy: cycle %0d got %b, expected 1", n, in_rdy);
                end
                push_exp(in_data);
            end
            for (int r = 0; r < ROWS; r++) begin
                exp_vld[r] = (n == 6 + r) || (n == 8 + r);
            end
            n_tests++;
            if (act_vld !== exp_vld) begin
                n_fail++;
                $display("FAIL underflow_vld: cycle %0d got %b, expected %b", n, act_vld, exp_vld);
            end
            n_tests++;
            if (clear !== (n == 1) || done !== (n == 12) || busy !== (n <= 12)) begin
                n_fail++;
                $display("FAIL underflow_ctrl: cycle %0d got clr=%b done=%b busy=%b, expected %b %b %b",
                         n, clear, done, busy, n == 1, n == 12, n <= 12);
            end
            for (int r = 0; r < ROWS; r++) begin
                got = act[r*DW +: DW];
                n_tests++;
                if (act_vld[r]) begin
                    if (exp_q[r].size() == 0) begin
                        n_fail++;
                        $display("FAIL underflow_lane%0d_extra: cycle %0d got %0d, expected none", r, n, got);
                    end else begin
                        want = exp_q[r].pop_front();
                        if (got !== want) begin
                            n_fail++;
                            $display("FAIL underflow_lane%0d_data: cycle %0d got %0d, expected %0d", r, n, got, want);
                        end
                    end
                end else if (got !== '0) begin
                    n_fail++;
                    $display("FAIL underflow_lane%0d_bubble: cycle %0d got %0d, expected 0", r, n, got);
                end
            end
            tick();
        end
        in_vld = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [ROWS-1:0] exp_vld;
        logic [DW-1:0]   got, want;
        logic [VW-1:0]   held;
        for (int p = 0; p < 4; p++) begin
            in_vld  = 1'b1;
            in_data = make_vec(16 * (p + 1), 1);
            @(negedge clk);
            n_tests++;
            if (in_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_fill_rdy: push %0d got %b, expected 1", p, in_rdy);
            end
            push_exp(in_data);
            tick();
        end
        held    = make_vec(16 * 5 + $urandom_range(0, 7), 1);
        in_data = held;
        start   = 1'b1;
        len     = LW'(5);
        @(negedge clk);
        n_tests++;
        if (in_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full_rdy: got %b, expected 0", in_rdy);
        end
        tick();
        start = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            n_tests++;
            if (in_rdy !== (n >= 3)) begin
                n_fail++;
                $display("FAIL b2b_rdy: cycle %0d got %b, expected %b", n, in_rdy, n >= 3);
            end
            if (n == 3) begin
                push_exp(held);
            end
            for (int r = 0; r < ROWS; r++) begin
                exp_vld[r] = (n >= 3 + r) && (n <= 7 + r);
            end
            n_tests++;
            if (act_vld !== exp_vld) begin
                n_fail++;
                $display("FAIL b2b_vld: cycle %0d got %b, expected %b", n, act_vld, exp_vld);
            end
            n_tests++;
            if (done !== (n == 11) || busy !== (n <= 11)) begin
                n_fail++;
                $display("FAIL b2b_ctrl: cycle %0d got done=%b busy=%b, expected %b %b", n, done, busy, n == 11, n <= 11);
            end
            for (int r = 0; r < ROWS; r++) begin
                got = act[r*DW +: DW];
                n_tests++;
                if (act_vld[r]) begin
                    if (exp_q[r].size() == 0) begin
                        n_fail++;
                        $display("FAIL b2b_lane%0d_extra: cycle %0d got %0d, expected none", r, n, got);
                    end else begin
                        want = exp_q[r].pop_front();
                        if (got !== want) begin
                            n_fail++;
                            $display("FAIL b2b_lane%0d_data: cycle %0d got %0d, expected %0d", r, n, got, want);
                        end
                    end
                end else if (got !== '0) begin
                    n_fail++;
                    $display("FAIL b2b_lane%0d_bubble: cycle %0d got %0d, expected 0", r, n, got);
                end
            end
            tick();
            if (n == 3) begin
                in_vld  = 1'b0;
                in_data = '0;
            end
        end
    endtask

    task automatic test_zero_len();
        start = 1'b1;
        len   = '0;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            n_tests++;
            if (done !== (n == 1) || busy !== (n == 1) || clear !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_len_ctrl: cycle %0d got done=%b busy=%b clr=%b, expected %b %b 0",
                         n, done, busy, clear, n == 1, n == 1);
            end
            n_tests++;
            if (act_vld !== '0 || act !== '0) begin
                n_fail++;
                $display("FAIL zero_len_act: cycle %0d got vld=%b act=%h, expected 0", n, act_vld, act);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [ROWS-1:0] exp_vld;
        logic [DW-1:0]   got, want;
        for (int k = 0; k < 2; k++) begin
            in_vld  = 1'b1;
            in_data = make_vec(100 + 10 * k, 1);
            tick();
        end
        in_vld = 1'b0;
        start  = 1'b1;
        len    = LW'(4);
        tick();
        start  = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({act, act_vld, clear, busy, done} !== '0 || in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_outputs: got act=%h vld=%b clr=%b busy=%b done=%b rdy=%b, expected zeros and rdy=1",
                     act, act_vld, clear, busy, done, in_rdy);
        end
        flush_exp();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        start = 1'b1;
        len   = LW'(1);
        tick();
        start = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            in_vld  = (n == 9);
            in_data = (n == 9) ? make_vec(8'hA0, 1) : '0;
            @(negedge clk);
            if (n == 9) begin
                n_tests++;
                if (in_rdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midreset_rdy: got %b, expected 1", in_rdy);
                end
                push_exp(in_data);
            end
            for (int r = 0; r < ROWS; r++) begin
                exp_vld[r] = (n == 11 + r);
            end
            n_tests++;
            if (act_vld !== exp_vld) begin
                n_fail++;
                $display("FAIL midreset_vld: cycle %0d got %b, expected %b", n, act_vld, exp_vld);
            end
            n_tests++;
            if (clear !== (n == 1) || done !== (n == 15) || busy !== (n <= 15)) begin
                n_fail++;
                $display("FAIL midreset_ctrl: cycle %0d got clr=%b done=%b busy=%b, expected %b %b %b",
                         n, clear, done, busy, n == 1, n == 15, n <= 15);
            end
            for (int r = 0; r < ROWS; r++) begin
                got = act[r*DW +: DW];
                n_tests++;
                if (act_vld[r]) begin
                    if (exp_q[r].size() == 0) begin
                        n_fail++;
                        $display("FAIL midreset_lane%0d_extra: cycle %0d got %0d, expected none", r, n, got);
                    end else begin
                        want = exp_q[r].pop_front();
                        if (got !== want) begin
                            n_fail++;
                            $display("FAIL midreset_lane%0d_data: cycle %0d got %0d, expected %0d", r, n, got, want);
                        end
                    end
                end else if (got !== '0) begin
                    n_fail++;
                    $display("FAIL midreset_lane%0d_stale: cycle %0d got %0d, expected 0", r, n, got);
                end
            end
            tick();
        end
        in_vld = 1'b0;
    endtask

    // ---------------- clock/reset and sequencing ----------------
    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        len     = '0;
        in_vld  = 1'b0;
        in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_prefill();
        test_underflow();
        test_back_to_back();
        test_zero_len();
        test_reset_mid_stream();

        for (int r = 0; r < ROWS; r++) begin
            n_tests++;
            if (exp_q[r].size() != 0) begin
                n_fail++;
                $display("FAIL lane%0d_leftover: got %0d undelivered vectors, expected 0", r, exp_q[r].size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
